// File: rtl/mac_lut_signed.sv
// Signed multiply-accumulate tile: registered operands -> LUT multiplier -> registered product -> accumulator.
// Optional build macro MAC_LUT_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module mac_lut_signed #(
    parameter int BITWIDTH     = 6,
    parameter int NUM_TERMS    = 8,
    parameter int ACC_BITWIDTH = 16
) (
    input  logic                    CLK_SYS,
    input  logic                    RSTN,
    input  logic                    CLR,
    input  logic                    DIN_VALID,
    output logic                    DIN_READY,
    input  logic [BITWIDTH-1:0]     A,
    input  logic [BITWIDTH-1:0]     B,
    output logic                    DOUT_VALID,
    input  logic                    DOUT_READY,
    output logic [ACC_BITWIDTH-1:0] Q,
    output logic                    OVF
);

    localparam int PW = 2 * BITWIDTH;
    localparam int CW = $clog2(NUM_TERMS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_TERMS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

`ifdef MAC_LUT_SATURATE_EN
    localparam logic [ACC_BITWIDTH-1:0] ACC_MAX = {1'b0, {(ACC_BITWIDTH-1){1'b1}}};
    localparam logic [ACC_BITWIDTH-1:0] ACC_MIN = {1'b1, {(ACC_BITWIDTH-1){1'b0}}};
`endif

    logic [1:0]              state_r, state_next_s;
    logic [CW-1:0]           count_r, count_next_s;
    logic                    din_ready_r, dout_valid_r;
    logic [BITWIDTH-1:0]     a_r, b_r;
    logic                    s1_valid_r, s1_last_r, s2_valid_r, s2_last_r;
    logic [PW-1:0]           mul_p_s, prod_r;
    logic [ACC_BITWIDTH-1:0] acc_r, acc_next_s, q_r;
    logic [ACC_BITWIDTH-1:0] prod_ext_s, sum_s, acc_add_s;
    logic                    ovf_r, ovf_next_s, add_ovf_s;
    logic                    in_xfer_s, out_xfer_s, last_in_s;

    // Two's-complement add overflows when both operands share a sign the sum does not.
    function automatic logic add_overflow(input logic x_msb, input logic y_msb, input logic s_msb);
        return (x_msb == y_msb) && (s_msb != x_msb);
    endfunction

    mac_lut_signed_mul #(.BITWIDTH(BITWIDTH)) u_mul (
        .a (a_r),
        .b (b_r),
        .p (mul_p_s)
    );

    assign DIN_READY  = din_ready_r;
    assign DOUT_VALID = dout_valid_r;
    assign Q          = q_r;
    assign OVF        = ovf_r;

    // Handshakes, product sign extension and the overflow-aware accumulate.
    always_comb begin
        in_xfer_s  = DIN_VALID & din_ready_r & ~CLR;
        out_xfer_s = dout_valid_r & DOUT_READY;
        last_in_s  = in_xfer_s && (count_r == LAST_CNT);
        prod_ext_s = ACC_BITWIDTH'($signed(prod_r));
        sum_s      = acc_r + prod_ext_s;
        add_ovf_s  = add_overflow(acc_r[ACC_BITWIDTH-1], prod_ext_s[ACC_BITWIDTH-1],
                                  sum_s[ACC_BITWIDTH-1]);
`ifdef MAC_LUT_SATURATE_EN
        if (add_ovf_s) begin
            acc_add_s = acc_r[ACC_BITWIDTH-1] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_add_s = sum_s;
        end
`else
        acc_add_s = sum_s;
`endif
    end

    // Next-state, term counter and accumulator update; CLR overrides everything.
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        acc_next_s   = acc_r;
        ovf_next_s   = ovf_r;
        case (state_r)
            ST_IDLE:  if (in_xfer_s) state_next_s = last_in_s ? ST_DRAIN : ST_RUN;
                      else state_next_s = ST_IDLE;
            ST_RUN:   if (last_in_s) state_next_s = ST_DRAIN;
                      else state_next_s = ST_RUN;
            ST_DRAIN: if (s2_valid_r && s2_last_r) state_next_s = ST_DONE;
                      else state_next_s = ST_DRAIN;
            ST_DONE:  if (out_xfer_s) state_next_s = ST_IDLE;
                      else state_next_s = ST_DONE;
            default:  state_next_s = ST_IDLE;
        endcase
        if (CLR || out_xfer_s) begin
            state_next_s = CLR ? ST_IDLE : state_next_s;
            count_next_s = '0;
            acc_next_s   = '0;
            ovf_next_s   = 1'b0;
        end else begin
            if (in_xfer_s) begin
                count_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                count_next_s = count_r;
            end
            if (s2_valid_r) begin
                acc_next_s = acc_add_s;
                ovf_next_s = ovf_r | add_ovf_s;
            end else begin
                acc_next_s = acc_r;
                ovf_next_s = ovf_r;
            end
        end
    end

    // Operand and product pipeline; only valid entries move, so bubbles never reach the accumulator.
    always_ff @(posedge CLK_SYS or negedge RSTN) begin
        if (!RSTN) begin
            a_r        <= '0;
            b_r        <= '0;
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            prod_r     <= '0;
            s2_valid_r <= 1'b0;
            s2_last_r  <= 1'b0;
        end else if (CLR) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s2_valid_r <= 1'b0;
            s2_last_r  <= 1'b0;
        end else begin
            s1_valid_r <= in_xfer_s;
            if (in_xfer_s) begin
                a_r       <= A;
                b_r       <= B;
                s1_last_r <= last_in_s;
            end
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                prod_r    <= mul_p_s;
                s2_last_r <= s1_last_r;
            end
        end
    end

    // Control state and registered outputs; Q mirrors the accumulator so it holds while in DONE.
    always_ff @(posedge CLK_SYS or negedge RSTN) begin
        if (!RSTN) begin
            state_r      <= ST_IDLE;
            count_r      <= '0;
            acc_r        <= '0;
            ovf_r        <= 1'b0;
            q_r          <= '0;
            din_ready_r  <= 1'b0;
            dout_valid_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            count_r      <= count_next_s;
            acc_r        <= acc_next_s;
            ovf_r        <= ovf_next_s;
            q_r          <= acc_next_s;
            din_ready_r  <= (state_next_s == ST_IDLE) || (state_next_s == ST_RUN);
            dout_valid_r <= (state_next_s == ST_DONE);
        end
    end

endmodule

// Combinational signed multiplier: magnitudes are multiplied digit-by-digit (radix 4) using
// a table of 0/1/2/3 multiples of |b|, then the sign is re-applied.
module mac_lut_signed_mul #(
    parameter int BITWIDTH = 6
) (
    input  logic [BITWIDTH-1:0]   a,
    input  logic [BITWIDTH-1:0]   b,
    output logic [2*BITWIDTH-1:0] p
);

    localparam int PW     = 2 * BITWIDTH;
    localparam int DIGITS = (BITWIDTH + 1) / 2;
    localparam int MW     = 2 * DIGITS;
    localparam int LW     = BITWIDTH + 2;

    logic [BITWIDTH-1:0] mag_a_s, mag_b_s;
    logic [MW-1:0]       mag_a_pad_s;
    logic [LW-1:0]       mult_lut_s [4];
    logic [PW-1:0]       mag_p_s;

    // Magnitude table lookup and shift-add; the most-negative operand's magnitude still fits BITWIDTH bits unsigned.
    always_comb begin
        if (a[BITWIDTH-1]) begin
            mag_a_s = ~a + {{(BITWIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag_a_s = a;
        end
        if (b[BITWIDTH-1]) begin
            mag_b_s = ~b + {{(BITWIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag_b_s = b;
        end
        mag_a_pad_s   = MW'(mag_a_s);
        mult_lut_s[0] = '0;
        mult_lut_s[1] = LW'(mag_b_s);
        mult_lut_s[2] = LW'({mag_b_s, 1'b0});
        mult_lut_s[3] = mult_lut_s[1] + mult_lut_s[2];
        mag_p_s = '0;
        for (int d = 0; d < DIGITS; d++) begin
            mag_p_s = mag_p_s + (PW'(mult_lut_s[mag_a_pad_s[2*d +: 2]]) << (2 * d));
        end
        if (a[BITWIDTH-1] ^ b[BITWIDTH-1]) begin
            p = ~mag_p_s + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            p = mag_p_s;
        end
    end

endmodule

// File: tb/tb_mac_lut_signed.sv
// Directed, table-driven bench for mac_lut_signed (BITWIDTH=6, NUM_TERMS=4, ACC_BITWIDTH=12).
module tb_mac_lut_signed;

    localparam int BW = 6;
    localparam int NT = 4;
    localparam int AW = 12;

`ifdef MAC_LUT_SATURATE_EN
    localparam int EXP_OVF4   = 2047;
    localparam int EXP_RECOV  = 63;
    localparam int EXP_MIDRST = 2047;
`else
    localparam int EXP_OVF4   = 0;
    localparam int EXP_RECOV  = 64;
    localparam int EXP_MIDRST = -2048;
`endif

    typedef struct {
        string name;
        int    a [NT];
        int    b [NT];
        int    gap;
        int    hold;
        int    exp_q;
        int    exp_ovf;
    } vec_t;

    logic          CLK_SYS = 1'b0;
    logic          RSTN, CLR, DIN_VALID, DIN_READY, DOUT_VALID, DOUT_READY, OVF;
    logic [BW-1:0] A, B;
    logic [AW-1:0] Q;

    int checks   = 0;
    int failures = 0;
    vec_t vecs [7];

    mac_lut_signed #(.BITWIDTH(BW), .NUM_TERMS(NT), .ACC_BITWIDTH(AW)) dut (
        .CLK_SYS    (CLK_SYS),
        .RSTN       (RSTN),
        .CLR        (CLR),
        .DIN_VALID  (DIN_VALID),
        .DIN_READY  (DIN_READY),
        .A          (A),
        .B          (B),
        .DOUT_VALID (DOUT_VALID),
        .DOUT_READY (DOUT_READY),
        .Q          (Q),
        .OVF        (OVF)
    );

    always #5 CLK_SYS = ~CLK_SYS;

    task automatic tick;
        @(posedge CLK_SYS);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int qs();
        return int'($signed(Q));
    endfunction

    task automatic run_vec(input vec_t v);
        int w;
        DOUT_READY = (v.hold == 0);
        for (int i = 0; i < NT; i++) begin
            A = v.a[i][BW-1:0];
            B = v.b[i][BW-1:0];
            DIN_VALID = 1'b1;
            w = 0;
            while (!DIN_READY && w < 20) begin
                tick;
                w++;
            end
            chk({v.name, "_din_ready"}, int'(DIN_READY), 1);
            tick;
            if (v.gap != 0 && i < NT - 1) begin
                DIN_VALID = 1'b0;
                tick;
            end
        end
        DIN_VALID = 1'b0;
        chk({v.name, "_drain_ready"}, int'(DIN_READY), 0);
        tick;
        chk({v.name, "_valid_early"}, int'(DOUT_VALID), 0);
        tick;
        chk({v.name, "_valid_t3"}, int'(DOUT_VALID), 1);
        chk({v.name, "_q"}, qs(), v.exp_q);
        chk({v.name, "_ovf"}, int'(OVF), v.exp_ovf);
        for (int h = 0; h < v.hold; h++) begin
            tick;
            chk({v.name, "_hold_valid"}, int'(DOUT_VALID), 1);
            chk({v.name, "_hold_q"}, qs(), v.exp_q);
            chk({v.name, "_hold_ovf"}, int'(OVF), v.exp_ovf);
            chk({v.name, "_hold_din_ready"}, int'(DIN_READY), 0);
        end
        DOUT_READY = 1'b1;
        tick;
        chk({v.name, "_consumed"}, int'(DOUT_VALID), 0);
        chk({v.name, "_ready_after"}, int'(DIN_READY), 1);
        DOUT_READY = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"basic",   '{3, -2, -32, 31},    '{5, 7, -32, -1},     0, 0, 994,       0};
        vecs[1] = '{"gaphold", '{3, -2, -32, 31},    '{5, 7, -32, -1},     1, 5, 994,       0};
        vecs[2] = '{"ovf4",    '{-32, -32, -32, -32}, '{-32, -32, -32, -32}, 0, 0, EXP_OVF4, 1};
        vecs[3] = '{"pos4",    '{1, 1, 1, 1},        '{1, 1, 1, 1},        0, 0, 4,         0};
        vecs[4] = '{"neg4",    '{-1, -1, -1, -1},    '{1, 1, 1, 1},        0, 0, -4,        0};
        vecs[5] = '{"mixed",   '{31, -32, 0, -1},    '{31, 31, 5, -1},     1, 2, -30,       0};
        vecs[6] = '{"recover", '{-32, -32, -32, -32}, '{-32, -32, 31, 31},  0, 0, EXP_RECOV, 1};

        RSTN = 1'b1; CLR = 1'b0; DIN_VALID = 1'b0; DOUT_READY = 1'b0; A = '0; B = '0;
        #2 RSTN = 1'b0;
        tick;
        tick;
        chk("rst_din_ready", int'(DIN_READY), 0);
        chk("rst_dout_valid", int'(DOUT_VALID), 0);
        chk("rst_q", qs(), 0);
        chk("rst_ovf", int'(OVF), 0);
        RSTN = 1'b1;
        tick;
        chk("rst_release_ready", int'(DIN_READY), 1);

        for (int k = 0; k < 7; k++) begin
            run_vec(vecs[k]);
        end

        // Abort after two pairs; the pair offered alongside CLR must be ignored.
        DOUT_READY = 1'b1;
        A = 6'd2; B = 6'd3; DIN_VALID = 1'b1;
        tick;
        tick;
        CLR = 1'b1;
        tick;
        CLR = 1'b0; DIN_VALID = 1'b0;
        chk("clr_valid", int'(DOUT_VALID), 0);
        chk("clr_ready", int'(DIN_READY), 1);
        chk("clr_q", qs(), 0);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("clr_no_output", int'(DOUT_VALID), 0);
        end
        chk("clr_q_flushed", qs(), 0);
        run_vec('{"after_clr", '{2, 2, 2, 2}, '{3, 3, 3, 3}, 0, 0, 24, 0});

        // Asynchronous reset in the middle of DRAIN.
        DOUT_READY = 1'b0;
        A = 6'b100000; B = 6'b100000; DIN_VALID = 1'b1;
        for (int i = 0; i < NT; i++) tick;
        DIN_VALID = 1'b0;
        chk("midrst_pre_q", qs(), EXP_MIDRST);
        chk("midrst_pre_ovf", int'(OVF), 1);
        chk("midrst_pre_ready", int'(DIN_READY), 0);
        #2 RSTN = 1'b0;
        #1;
        chk("midrst_valid", int'(DOUT_VALID), 0);
        chk("midrst_q", qs(), 0);
        chk("midrst_ovf", int'(OVF), 0);
        chk("midrst_ready", int'(DIN_READY), 0);
        tick;
        RSTN = 1'b1;
        tick;
        chk("midrst_release_ready", int'(DIN_READY), 1);
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_output", int'(DOUT_VALID), 0);
            tick;
        end
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_lut_signed.md
Name: mac_lut_signed

Overview:
- Downstream consumer of the combinational LUT-based signed multiplier.
- Accepts a stream of signed operand pairs, registers them, and multiplies them through one internal LUT signed-multiplier instance.
- Accumulates NUM_TERMS products into one signed dot-product result and presents it on a valid/ready output port.
- Used as the MAC tile for the small dense-layer test designs on the Arty A7.

Parameters:
BITWIDTH, 6, operand width; product width is 2*BITWIDTH
NUM_TERMS, 8, products accumulated per result (>=2)
ACC_BITWIDTH, 16, accumulator/result width (>=2*BITWIDTH)

Ports:
CLK_SYS  in  1  system clock; all registers on rising edge
RSTN  in  1  reset; asynchronous assertion, active-low
CLR  in  1  synchronous abort/clear, highest priority after reset
DIN_VALID  in  1  operand pair valid
DIN_READY  out  1  block can accept an operand pair
A  in  BITWIDTH  signed operand A
B  in  BITWIDTH  signed operand B
DOUT_VALID  out  1  result valid
DOUT_READY  in  1  downstream accepts result
Q  out  ACC_BITWIDTH  signed accumulated result
OVF  out  1  sticky: accumulation overflowed during the current result

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Clock port is CLK_SYS; reset port is RSTN.
- Reset (RSTN=0): state IDLE; term count 0; accumulator 0; pipeline valids 0; DIN_READY=0 during reset; DOUT_VALID=0; Q=0; OVF=0.
- Handshake: a transfer occurs on a cycle where VALID=1 and READY=1.
- DIN_READY=1 in IDLE and RUN. DIN_READY=0 in DRAIN and DONE.
- Pipeline for each accepted pair:
  - stage 1: A and B are registered.
  - stage 2: the multiplier output (2*BITWIDTH, signed) is registered.
  - accumulate: the product is sign-extended to ACC_BITWIDTH and added into the accumulator.
- Accumulator starts from 0 for each result.
- Term counter increments on every input transfer.
- State machine:
  - IDLE -> RUN on the first input transfer.
  - RUN -> DRAIN on the transfer that makes count = NUM_TERMS.
  - DRAIN -> DONE when the final product has been accumulated.
  - DONE -> IDLE on the output transfer. In the same cycle, count, accumulator and OVF clear.
- Latency: if the last pair is accepted at cycle t, DOUT_VALID=1 from cycle t+3.
- Gaps: DIN_VALID gaps in RUN are legal. The pipeline advances only valid entries; bubbles add nothing.
- Back-to-back input is supported at 1 pair/cycle.
- Output hold: in DONE, Q and OVF are held stable until DOUT_READY=1. Q is a registered copy of the accumulator.
- If DOUT_READY=1 already when DOUT_VALID rises, the result is consumed in that first cycle. DIN_READY is asserted the next cycle.
- Overflow: signed overflow of the accumulator add sets OVF (sticky per result). Without the optional feature, the sum wraps two's-complement.
- CLR=1: return to IDLE next edge; pipeline valids, count, accumulator and OVF clear; DOUT_VALID drops. Any input transfer in the same cycle is ignored.
- Reset mid-operation: all state discarded immediately; no partial result is ever emitted.
- Edge operands: the most-negative operands (e.g. -32*-32 at BITWIDTH=6) must produce +1024 exactly.

Optional Feature:
- Macro: MAC_LUT_SATURATE_EN.
- Defined: on signed overflow the accumulator clamps to the most-positive value (2^(ACC_BITWIDTH-1)-1) or most-negative value (-2^(ACC_BITWIDTH-1)). It stays clamped until a later product moves it back in range. OVF still sets.
- Undefined: two's-complement wrap-around; OVF flags the event only.

Test Plan:
1. Setup: BITWIDTH=6, NUM_TERMS=4, ACC_BITWIDTH=16. Pairs (3,5), (-2,7), (-32,-32), (31,-1) back-to-back, DOUT_READY=1 -> Q=994, OVF=0, DOUT_VALID exactly 3 cycles after the 4th accept, for 1 cycle.
2. Same pairs with DIN_VALID toggling every other cycle, then DOUT_READY held 0 for 5 cycles -> Q=994 held stable, DIN_READY=0 throughout DONE. Accept occurs on the first DOUT_READY=1; DIN_READY=1 next cycle.
3. ACC_BITWIDTH=12, 4×(-32,-32) -> without the macro Q=0, OVF=1. With MAC_LUT_SATURATE_EN Q=2047, OVF=1.
4. Two consecutive results: (1,1)×4 then (-1,1)×4 -> Q=4 then Q=-4. The second result is not contaminated by the first.
5. CLR pulsed after 2 of 4 pairs, then (2,3)×4 -> single result Q=24; no output for the aborted set.
6. RSTN asserted asynchronously mid-DRAIN (between clock edges) -> DOUT_VALID, Q, OVF=0 immediately. After release the block is in IDLE with DIN_READY=1 on the first clock edge.
